// File: rtl/am29xx_slice_pair.sv
// One 4-bit Am2901-style ALU slice plus one 4-bit Am2909/Am2911-style
// microprogram sequencer slice. The two halves share clock and reset only.
// Carry chains leave the slice so several slices can be cascaded.
module am29xx_slice_pair #(
  parameter bit SEQ_2909 = 1'b1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] alu_din,
  input  logic [3:0] alu_a,
  input  logic [3:0] alu_b,
  input  logic [2:0] alu_src,
  input  logic [2:0] alu_op,
  input  logic [2:0] alu_dest,
  input  logic       alu_cin,
  input  logic       ram0_in,
  input  logic       ram3_in,
  input  logic       q0_in,
  input  logic       q3_in,
  output logic [3:0] alu_y,
  output logic       alu_cout,
  output logic       alu_zero,
  output logic       alu_f3,
  output logic       alu_ovr,
  input  logic [3:0] seq_din,
  input  logic [3:0] seq_rin,
  input  logic [3:0] seq_orin,
  input  logic [1:0] seq_s,
  input  logic       seq_zero_n,
  input  logic       seq_cin,
  input  logic       seq_re_n,
  input  logic       seq_fe_n,
  input  logic       seq_pup,
  output logic [3:0] seq_y,
  output logic       seq_cout
);

  // ALU function unit: returns {ovr, cout, F}. Subtraction forms invert one
  // operand and rely on cin for the two's-complement +1.
  function automatic logic [5:0] alu_func(input logic [2:0] op,
                                          input logic [3:0] r,
                                          input logic [3:0] s,
                                          input logic       cin);
    logic [3:0] x;
    logic [3:0] y;
    logic [4:0] sum;
    logic [3:0] low;
    logic [5:0] res;
    x   = r;
    y   = s;
    res = 6'd0;
    case (op)
      3'd1:    x = ~r;
      3'd2:    y = ~s;
      default: ;
    endcase
    sum = {1'b0, x} + {1'b0, y} + {4'd0, cin};
    low = {1'b0, x[2:0]} + {1'b0, y[2:0]} + {3'd0, cin};
    case (op)
      3'd0, 3'd1, 3'd2: res = {low[3] ^ sum[4], sum[4], sum[3:0]};
      3'd3:    res = {2'b00, r | s};
      3'd4:    res = {2'b00, r & s};
      3'd5:    res = {2'b00, ~r & s};
      3'd6:    res = {2'b00, r ^ s};
      default: res = {2'b00, ~(r ^ s)};
    endcase
    return res;
  endfunction

  logic [3:0] ram [16];
  logic [3:0] q_reg;
  logic [3:0] a_data;
  logic [3:0] b_data;
  logic [3:0] r_opnd;
  logic [3:0] s_opnd;
  logic [3:0] alu_f;
  logic [5:0] alu_res;

  assign a_data = ram[alu_a];
  assign b_data = ram[alu_b];

  // Operand source selection (R,S)
  always_comb begin
    r_opnd = 4'd0;
    s_opnd = 4'd0;
    case (alu_src)
      3'd0: begin r_opnd = a_data;  s_opnd = q_reg;  end
      3'd1: begin r_opnd = a_data;  s_opnd = b_data; end
      3'd2: begin r_opnd = 4'd0;    s_opnd = q_reg;  end
      3'd3: begin r_opnd = 4'd0;    s_opnd = b_data; end
      3'd4: begin r_opnd = 4'd0;    s_opnd = a_data; end
      3'd5: begin r_opnd = alu_din; s_opnd = a_data; end
      3'd6: begin r_opnd = alu_din; s_opnd = q_reg;  end
      default: begin r_opnd = alu_din; s_opnd = 4'd0; end
    endcase
  end

  assign alu_res  = alu_func(alu_op, r_opnd, s_opnd, alu_cin);
  assign alu_f    = alu_res[3:0];
  assign alu_cout = alu_res[4];
  assign alu_ovr  = alu_res[5];
  assign alu_zero = (alu_f == 4'd0);
  assign alu_f3   = alu_f[3];
  assign alu_y    = (alu_dest == 3'd2) ? a_data : alu_f;

  // RAM and Q register updates, including the up/down shift paths
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) ram[i] <= 4'd0;
      q_reg <= 4'd0;
    end else begin
      case (alu_dest)
        3'd2, 3'd3: ram[alu_b] <= alu_f;
        3'd4, 3'd5: ram[alu_b] <= {ram3_in, alu_f[3:1]};
        3'd6, 3'd7: ram[alu_b] <= {alu_f[2:0], ram0_in};
        default: ;
      endcase
      case (alu_dest)
        3'd0: q_reg <= alu_f;
        3'd4: q_reg <= {q3_in, q_reg[3:1]};
        3'd6: q_reg <= {q_reg[2:0], q0_in};
        default: ;
      endcase
    end
  end

  logic [3:0] upc;
  logic [3:0] ar;
  logic [3:0] stack [4];
  logic [1:0] sp;
  logic [1:0] sp_inc;
  logic [3:0] seq_mux;

  assign sp_inc = sp + 2'd1;

  // Sequencer address source selection
  always_comb begin
    seq_mux = 4'd0;
    case (seq_s)
      2'd0:    seq_mux = upc;
      2'd1:    seq_mux = ar;
      2'd2:    seq_mux = stack[sp];
      default: seq_mux = seq_din;
    endcase
  end

  // The Am2911 variant has no OR inputs, so they are masked off here.
  assign seq_y    = seq_zero_n ? (seq_mux | (SEQ_2909 ? seq_orin : 4'd0)) : 4'd0;
  assign seq_cout = seq_cin & (seq_y == 4'hF);

  // uPC, address register and push/pop stack; a push saves the pre-edge uPC
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      upc <= 4'd0;
      ar  <= 4'd0;
      sp  <= 2'd0;
      for (int i = 0; i < 4; i++) stack[i] <= 4'd0;
    end else begin
      upc <= seq_y + {3'd0, seq_cin};
      if (!seq_re_n) ar <= SEQ_2909 ? seq_rin : seq_din;
      if (!seq_fe_n) begin
        if (seq_pup) begin
          sp            <= sp_inc;
          stack[sp_inc] <= upc;
        end else begin
          sp <= sp - 2'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_am29xx_slice_pair.sv
// Directed-vector bench for am29xx_slice_pair: one Am2909 instance and one
// Am2911 instance driven from the same stimulus.
module tb_am29xx_slice_pair;

  logic       clock;
  logic       reset;
  logic [3:0] alu_din, alu_a, alu_b;
  logic [2:0] alu_src, alu_op, alu_dest;
  logic       alu_cin, ram0_in, ram3_in, q0_in, q3_in;
  logic [3:0] alu_y, alu_y11;
  logic       alu_cout, alu_zero, alu_f3, alu_ovr;
  logic       alu_cout11, alu_zero11, alu_f311, alu_ovr11;
  logic [3:0] seq_din, seq_rin, seq_orin;
  logic [1:0] seq_s;
  logic       seq_zero_n, seq_cin, seq_re_n, seq_fe_n, seq_pup;
  logic [3:0] seq_y, seq_y11;
  logic       seq_cout, seq_cout11;

  int checks   = 0;
  int failures = 0;

  am29xx_slice_pair #(.SEQ_2909(1'b1)) dut (
    .clock(clock), .reset(reset),
    .alu_din(alu_din), .alu_a(alu_a), .alu_b(alu_b),
    .alu_src(alu_src), .alu_op(alu_op), .alu_dest(alu_dest), .alu_cin(alu_cin),
    .ram0_in(ram0_in), .ram3_in(ram3_in), .q0_in(q0_in), .q3_in(q3_in),
    .alu_y(alu_y), .alu_cout(alu_cout), .alu_zero(alu_zero), .alu_f3(alu_f3),
    .alu_ovr(alu_ovr),
    .seq_din(seq_din), .seq_rin(seq_rin), .seq_orin(seq_orin), .seq_s(seq_s),
    .seq_zero_n(seq_zero_n), .seq_cin(seq_cin), .seq_re_n(seq_re_n),
    .seq_fe_n(seq_fe_n), .seq_pup(seq_pup), .seq_y(seq_y), .seq_cout(seq_cout)
  );

  am29xx_slice_pair #(.SEQ_2909(1'b0)) dut11 (
    .clock(clock), .reset(reset),
    .alu_din(alu_din), .alu_a(alu_a), .alu_b(alu_b),
    .alu_src(alu_src), .alu_op(alu_op), .alu_dest(alu_dest), .alu_cin(alu_cin),
    .ram0_in(ram0_in), .ram3_in(ram3_in), .q0_in(q0_in), .q3_in(q3_in),
    .alu_y(alu_y11), .alu_cout(alu_cout11), .alu_zero(alu_zero11),
    .alu_f3(alu_f311), .alu_ovr(alu_ovr11),
    .seq_din(seq_din), .seq_rin(seq_rin), .seq_orin(seq_orin), .seq_s(seq_s),
    .seq_zero_n(seq_zero_n), .seq_cin(seq_cin), .seq_re_n(seq_re_n),
    .seq_fe_n(seq_fe_n), .seq_pup(seq_pup), .seq_y(seq_y11),
    .seq_cout(seq_cout11)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then step off the edge before driving/sampling
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic alu_set(input logic [2:0] src, input logic [2:0] op,
                         input logic [2:0] dest, input logic cin,
                         input logic [3:0] din, input logic [3:0] a,
                         input logic [3:0] b);
    alu_src = src; alu_op = op; alu_dest = dest; alu_cin = cin;
    alu_din = din; alu_a = a; alu_b = b;
    #1;
  endtask

  initial begin
    reset = 1'b0;
    alu_din = 0; alu_a = 0; alu_b = 0; alu_src = 0; alu_op = 0; alu_dest = 1;
    alu_cin = 0; ram0_in = 0; ram3_in = 0; q0_in = 0; q3_in = 0;
    seq_din = 0; seq_rin = 0; seq_orin = 0; seq_s = 0; seq_zero_n = 1;
    seq_cin = 0; seq_re_n = 1; seq_fe_n = 1; seq_pup = 0;
    #12;
    check("rst_alu_y", {4'd0, alu_y}, 8'h00);
    check("rst_alu_zero", {7'd0, alu_zero}, 8'h01);
    check("rst_seq_y", {4'd0, seq_y}, 8'h00);
    tick();
    reset = 1'b1;
    tick();

    // RAM[2] <= D=5, then 0+B+1 = 6
    alu_set(3'd7, 3'd0, 3'd3, 1'b0, 4'd5, 4'd0, 4'd2);
    tick();
    alu_set(3'd3, 3'd0, 3'd1, 1'b1, 4'd0, 4'd0, 4'd2);
    check("add_b_cin_y", {4'd0, alu_y}, 8'h06);
    check("add_b_cin_cout", {7'd0, alu_cout}, 8'h00);
    check("add_b_cin_zero", {7'd0, alu_zero}, 8'h00);

    // RAM1=7, RAM2=1; A+B overflows into bit 3
    alu_set(3'd7, 3'd0, 3'd3, 1'b0, 4'd7, 4'd0, 4'd1);
    tick();
    alu_set(3'd7, 3'd0, 3'd3, 1'b0, 4'd1, 4'd0, 4'd2);
    tick();
    alu_set(3'd1, 3'd0, 3'd1, 1'b0, 4'd0, 4'd1, 4'd2);
    check("a_plus_b_y", {4'd0, alu_y}, 8'h08);
    check("a_plus_b_ovr", {7'd0, alu_ovr}, 8'h01);
    check("a_plus_b_f3", {7'd0, alu_f3}, 8'h01);
    check("a_plus_b_cout", {7'd0, alu_cout}, 8'h00);
    alu_set(3'd1, 3'd2, 3'd1, 1'b1, 4'd0, 4'd1, 4'd2);
    check("a_minus_b_y", {4'd0, alu_y}, 8'h06);
    check("a_minus_b_cout", {7'd0, alu_cout}, 8'h01);
    check("a_minus_b_ovr", {7'd0, alu_ovr}, 8'h00);
    alu_set(3'd1, 3'd6, 3'd1, 1'b1, 4'd0, 4'd1, 4'd2);
    check("xor_y", {4'd0, alu_y}, 8'h06);
    check("xor_cout", {7'd0, alu_cout}, 8'h00);
    alu_set(3'd1, 3'd4, 3'd2, 1'b0, 4'd0, 4'd1, 4'd2);
    check("dest2_y_is_a", {4'd0, alu_y}, 8'h07);
    alu_set(3'd1, 3'd7, 3'd1, 1'b0, 4'd0, 4'd1, 4'd2);
    check("xnor_y", {4'd0, alu_y}, 8'h09);
    check("xnor_zero", {7'd0, alu_zero}, 8'h00);

    // Q=9, then shift-down destination with F=4
    alu_set(3'd7, 3'd0, 3'd0, 1'b0, 4'd9, 4'd0, 4'd2);
    tick();
    q3_in = 1'b1; ram3_in = 1'b0;
    alu_set(3'd7, 3'd0, 3'd4, 1'b0, 4'd4, 4'd0, 4'd2);
    check("dest4_y", {4'd0, alu_y}, 8'h04);
    tick();
    alu_set(3'd2, 3'd3, 3'd1, 1'b0, 4'd0, 4'd0, 4'd2);
    check("shr_q", {4'd0, alu_y}, 8'h0C);
    alu_set(3'd3, 3'd3, 3'd1, 1'b0, 4'd0, 4'd0, 4'd2);
    check("shr_ram", {4'd0, alu_y}, 8'h02);

    // Shift-up destination: RAM3 <= {101,1}=B, Q <= {100,0}=8
    ram0_in = 1'b1; q0_in = 1'b0;
    alu_set(3'd7, 3'd0, 3'd6, 1'b0, 4'd5, 4'd0, 4'd3);
    tick();
    alu_set(3'd2, 3'd3, 3'd1, 1'b0, 4'd0, 4'd0, 4'd3);
    check("shl_q", {4'd0, alu_y}, 8'h08);
    alu_set(3'd3, 3'd3, 3'd1, 1'b0, 4'd0, 4'd0, 4'd3);
    check("shl_ram", {4'd0, alu_y}, 8'h0B);

    // Read-before-write with a==b: B+B=6 this cycle, 6+6=C next
    alu_set(3'd1, 3'd0, 3'd3, 1'b0, 4'd0, 4'd3, 4'd3);
    check("rbw_same_cycle", {4'd0, alu_y}, 8'h06);
    tick();
    alu_set(3'd1, 3'd0, 3'd1, 1'b0, 4'd0, 4'd3, 4'd3);
    check("rbw_next_cycle", {4'd0, alu_y}, 8'h0C);

    // Sequencer counting from uPC=0
    seq_s = 2'd0; seq_cin = 1'b1;
    #1;
    for (int i = 0; i <= 16; i++) begin
      check($sformatf("count_y%0d", i), {4'd0, seq_y}, 8'(i % 16));
      check($sformatf("count_cout%0d", i), {7'd0, seq_cout}, (i % 16 == 15) ? 8'h01 : 8'h00);
      if (i < 16) tick();
    end

    // Load uPC=3, push it, read top, pop back
    seq_s = 2'd3; seq_din = 4'd3; seq_cin = 1'b0;
    tick();
    seq_s = 2'd0; seq_fe_n = 1'b0; seq_pup = 1'b1;
    tick();
    seq_fe_n = 1'b1; seq_s = 2'd2;
    #1;
    check("push_top", {4'd0, seq_y}, 8'h03);
    seq_fe_n = 1'b0; seq_pup = 1'b0;
    #1;
    check("pop_shows_top", {4'd0, seq_y}, 8'h03);
    tick();
    seq_fe_n = 1'b1;
    #1;
    check("pop_sp0", {4'd0, seq_y}, 8'h00);

    // Five pushes with uPC 3..7: SP wraps to 1, stack[1] overwritten by 7
    seq_s = 2'd0; seq_cin = 1'b1; seq_fe_n = 1'b0; seq_pup = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    seq_fe_n = 1'b1; seq_s = 2'd2;
    #1;
    check("wrap_top", {4'd0, seq_y}, 8'h07);
    seq_fe_n = 1'b0; seq_pup = 1'b0;
    tick();
    seq_fe_n = 1'b1;
    #1;
    check("wrap_after_pop", {4'd0, seq_y}, 8'h06);

    // AR load: 2909 takes R, 2911 takes D; OR inputs only on 2909
    seq_cin = 1'b0; seq_re_n = 1'b0; seq_din = 4'hA; seq_rin = 4'h3;
    tick();
    seq_re_n = 1'b1; seq_s = 2'd1; seq_orin = 4'h5;
    #1;
    check("ar_2911", {4'd0, seq_y11}, 8'h0A);
    check("ar_2909_or", {4'd0, seq_y}, 8'h07);
    seq_zero_n = 1'b0; seq_cin = 1'b1;
    #1;
    check("zero_2911", {4'd0, seq_y11}, 8'h00);
    check("zero_2909", {4'd0, seq_y}, 8'h00);
    check("zero_cout", {7'd0, seq_cout}, 8'h00);

    // Run a few cycles, then assert reset asynchronously mid-cycle
    seq_zero_n = 1'b1; seq_orin = 4'h0; seq_s = 2'd0;
    tick();
    tick();
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_seq", {4'd0, seq_y}, 8'h00);
    check("async_rst_seq11", {4'd0, seq_y11}, 8'h00);
    alu_set(3'd3, 3'd3, 3'd1, 1'b0, 4'd0, 4'd0, 4'd3);
    check("async_rst_ram", {4'd0, alu_y}, 8'h00);
    alu_set(3'd2, 3'd3, 3'd1, 1'b0, 4'd0, 4'd0, 4'd3);
    check("async_rst_q", {4'd0, alu_y}, 8'h00);
    tick();
    reset = 1'b1;
    tick();
    #1;
    check("post_rst_count", {4'd0, seq_y}, 8'h01);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
